// File: rtl/wr_resp_pkg.sv
// wr_resp_pkg: shared defaults, LFSR seed/polynomial and step function for the write completion responder.
package wr_resp_pkg;
   localparam int TAG_WIDTH_DEF   = 6;
   localparam int ADDR_WIDTH_DEF  = 58;
   localparam int DATA_WIDTH_DEF  = 512;
   localparam int SLOT_BITS_DEF   = 4;
   localparam int BASE_LAT_DEF    = 4;
   localparam int JITTER_BITS_DEF = 3;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction
endpackage

// File: rtl/wr_completion_responder_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant over the slot request vector, search starting after the last grant.
module rr_arbiter
   import wr_resp_pkg::*;
#(
   parameter int SLOT_BITS = SLOT_BITS_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [(1<<SLOT_BITS)-1:0]   req,
   output logic [(1<<SLOT_BITS)-1:0]   gnt,
   output logic                        gnt_valid
);
   localparam int N = 1 << SLOT_BITS;
   logic [SLOT_BITS-1:0] ptr_q, ptr_d, idx;
   always_comb begin
      gnt = '0;
      gnt_valid = 1'b0;
      ptr_d = ptr_q;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         idx = ptr_q + SLOT_BITS'(i);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt[idx] = 1'b1;
            ptr_d = idx + SLOT_BITS'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end
endmodule

// File: rtl/wr_completion_responder.sv
// wr_completion_responder: accepts writes into delay slots, issues the backing-store write, returns completions.
// Define WR_RESP_REORDER_EN to add LFSR jitter to each slot delay (completions may then reorder).
module wr_completion_responder
   import wr_resp_pkg::*;
#(
   parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int SLOT_BITS   = SLOT_BITS_DEF,
   parameter int BASE_LAT    = BASE_LAT_DEF,
   parameter int JITTER_BITS = JITTER_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic                  req_valid,
   output logic                  req_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   output logic                  rsp_valid,
   output logic [SLOT_BITS:0]    outstanding
);
   localparam int NS = 1 << SLOT_BITS;
   localparam int CW = $clog2(BASE_LAT + (1 << JITTER_BITS));
   // The acceptance cycle is the first delay cycle, so grant lands BASE_LAT cycles after acceptance
   localparam logic [CW-1:0] LOAD = CW'(BASE_LAT - 1);
   logic [NS-1:0] occ_q, occ_d, elig, gnt;
   logic [CW-1:0] cnt_q [NS];
   logic [CW-1:0] cnt_d [NS];
   logic [TAG_WIDTH-1:0] tag_q [NS];
   logic [TAG_WIDTH-1:0] tag_d [NS];
   logic [SLOT_BITS:0] out_q, out_d;
   logic mem_we_q, mem_we_d, rsp_valid_q, rsp_valid_d, gnt_valid, accept;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d, gnt_tag;
   logic [SLOT_BITS-1:0] free_idx;
   logic [CW-1:0] jit;
`ifdef WR_RESP_REORDER_EN
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = accept ? lfsr_next(lfsr_q) : lfsr_q;
   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else lfsr_q <= lfsr_d;
   end
   assign jit = CW'(lfsr_q[JITTER_BITS-1:0]);
`else
   assign jit = '0;
`endif
   // outstanding never exceeds NS, so its MSB alone flags "full"
   assign req_ready = !out_q[SLOT_BITS];
   assign accept = req_valid && req_ready;
   always_comb begin
      free_idx = '0;
      elig = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (!occ_q[i]) free_idx = SLOT_BITS'(i);
         elig[i] = occ_q[i] && cnt_q[i] == '0;
      end
   end
   rr_arbiter #(.SLOT_BITS(SLOT_BITS)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (elig),
      .gnt      (gnt),
      .gnt_valid(gnt_valid)
   );
   always_comb begin
      occ_d = occ_q & ~gnt;
      cnt_d = cnt_q;
      tag_d = tag_q;
      gnt_tag = '0;
      for (int i = 0; i < NS; i++) begin
         if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
         if (gnt[i]) gnt_tag = tag_q[i];
      end
      if (accept) begin
         occ_d[free_idx] = 1'b1;
         cnt_d[free_idx] = LOAD + jit;
         tag_d[free_idx] = req_tag;
      end
      out_d = out_q + (SLOT_BITS+1)'(accept) - (SLOT_BITS+1)'(gnt_valid);
      mem_we_d = accept;
      mem_addr_d = accept ? req_addr : mem_addr_q;
      mem_data_d = accept ? req_data : mem_data_q;
      rsp_valid_d = gnt_valid;
      rsp_tag_d = gnt_tag;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q <= '0;
         out_q <= '0;
         mem_we_q <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tag_q <= '0;
         for (int i = 0; i < NS; i++) begin
            cnt_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         out_q <= out_d;
         mem_we_q <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tag_q <= rsp_tag_d;
         cnt_q <= cnt_d;
         tag_q <= tag_d;
      end
   end
   assign mem_we = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_tag = rsp_tag_q;
   assign outstanding = out_q;
endmodule
